riscv_imul_arb: RTL and testbench

RISCV_IMUL_ARB -- requirements
Module: riscv_imul_arb

---
 rtl/riscv_imul_arb_pkg.sv | 27 ++
 rtl/riscv_imul_arb_track.sv | 58 +++++
 rtl/riscv_imul_arb.sv | 103 ++++++++++
 tb/tb_riscv_imul_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_imul_arb_pkg.sv
// Shared widths, requester ids and the arbitration pick rule for the
// scalar/vector multiplier arbiter.
package riscv_imul_arb_pkg;

  // Datapath and opcode widths from the vuVXU configuration.
  localparam int XLEN      = 64;
  localparam int VAU0_FN_W = 2;

  typedef enum logic {
    REQ_SCALAR = 1'b0,
    REQ_VEC    = 1'b1
  } req_id_e;

  // A lone valid requester wins; under contention, the one not granted last wins.
  function automatic req_id_e rr_pick(input logic v0, input logic v1,
                                      input req_id_e last_grant);
    req_id_e pick;
    pick = REQ_SCALAR;
    if (v0 && v1) begin
      pick = (last_grant == REQ_SCALAR) ? REQ_VEC : REQ_SCALAR;
    end else if (v1) begin
      pick = REQ_VEC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/riscv_imul_arb_track.sv
// Fixed-latency in-flight tracker: carries {valid, id, tag} alongside the
// multiplier pipe and counts how many issues are still outstanding.
module riscv_imul_track
  import riscv_imul_arb_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int TAGW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fire,
  input  req_id_e         fire_id,
  input  logic [TAGW-1:0] fire_tag,
  output logic            resp_val,
  output req_id_e         resp_id,
  output logic [TAGW-1:0] resp_tag,
  output logic [3:0]      inflight
);

  logic [LATENCY-1:0] pipe_val;
  req_id_e            pipe_id  [LATENCY];
  logic [TAGW-1:0]    pipe_tag [LATENCY];
  logic [3:0]         count;

  // The pipe advances every cycle; the multiplier has no stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_val <= '0;
      count    <= 4'd0;
    end else begin
      pipe_val[0] <= fire;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_val[i] <= pipe_val[i-1];
      end
      case ({fire, pipe_val[LATENCY-1]})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Id/tag payload is only meaningful alongside its valid bit, so no reset.
  always_ff @(posedge clk) begin
    pipe_id[0]  <= fire_id;
    pipe_tag[0] <= fire_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_id[i]  <= pipe_id[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  assign resp_val = pipe_val[LATENCY-1];
  assign resp_id  = pipe_id[LATENCY-1];
  assign resp_tag = pipe_tag[LATENCY-1];
  assign inflight = count;

endmodule

// File: rtl/riscv_imul_arb.sv
// Round-robin arbiter sharing one fixed-latency multiplier between the scalar
// core (req0) and the vector unit (req1); results return without backpressure.
module riscv_imul_arb
  import riscv_imul_arb_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int TAGW    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_val,
  output logic                 req0_rdy,
  input  logic [VAU0_FN_W-1:0] req0_fn,
  input  logic [XLEN-1:0]      req0_in0,
  input  logic [XLEN-1:0]      req0_in1,
  input  logic [TAGW-1:0]      req0_tag,
  input  logic                 req1_val,
  output logic                 req1_rdy,
  input  logic [VAU0_FN_W-1:0] req1_fn,
  input  logic [XLEN-1:0]      req1_in0,
  input  logic [XLEN-1:0]      req1_in1,
  input  logic [TAGW-1:0]      req1_tag,
  output logic                 cp_imul_val,
  input  logic                 cp_imul_rdy,
  output logic [VAU0_FN_W-1:0] cp_imul_fn,
  output logic [XLEN-1:0]      cp_imul_in0,
  output logic [XLEN-1:0]      cp_imul_in1,
  input  logic [XLEN-1:0]      cp_imul_out,
  output logic                 resp0_val,
  output logic [TAGW-1:0]      resp0_tag,
  output logic                 resp1_val,
  output logic [TAGW-1:0]      resp1_tag,
  output logic [XLEN-1:0]      resp_bits,
  input  logic                 quiesce,
  output logic                 drained,
  output logic [3:0]           inflight
);

  // Handshake: a request transfers in any cycle where reqN_val && reqN_rdy;
  // cp_imul issues when cp_imul_val && cp_imul_rdy, and cp_imul_val never
  // looks at cp_imul_rdy.
  req_id_e         last_grant;
  req_id_e         sel;
  req_id_e         trk_id;
  logic            fire;
  logic            issue_ok;
  logic            trk_val;
  logic [TAGW-1:0] sel_tag;
  logic [TAGW-1:0] trk_tag;

  assign sel         = rr_pick(req0_val, req1_val, last_grant);
  assign cp_imul_val = (req0_val | req1_val) & ~quiesce;
  assign issue_ok    = cp_imul_rdy & ~quiesce;
  assign req0_rdy    = issue_ok & req0_val & (sel == REQ_SCALAR);
  assign req1_rdy    = issue_ok & req1_val & (sel == REQ_VEC);
  assign fire        = cp_imul_val & cp_imul_rdy;

  always_comb begin
    cp_imul_fn  = req0_fn;
    cp_imul_in0 = req0_in0;
    cp_imul_in1 = req0_in1;
    sel_tag     = req0_tag;
    if (sel == REQ_VEC) begin
      cp_imul_fn  = req1_fn;
      cp_imul_in0 = req1_in0;
      cp_imul_in1 = req1_in1;
      sel_tag     = req1_tag;
    end
  end

  // Resetting to REQ_VEC hands the first contention to the scalar core.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_VEC;
    end else if (fire) begin
      last_grant <= sel;
    end
  end

  riscv_imul_track #(
    .LATENCY (LATENCY),
    .TAGW    (TAGW)
  ) u_track (
    .clk      (clk),
    .reset    (reset),
    .fire     (fire),
    .fire_id  (sel),
    .fire_tag (sel_tag),
    .resp_val (trk_val),
    .resp_id  (trk_id),
    .resp_tag (trk_tag),
    .inflight (inflight)
  );

  // Gating with reset drops results still in the pipe when reset lands.
  assign resp0_val = trk_val & (trk_id == REQ_SCALAR) & ~reset;
  assign resp1_val = trk_val & (trk_id == REQ_VEC) & ~reset;
  assign resp0_tag = trk_tag;
  assign resp1_tag = trk_tag;
  assign resp_bits = cp_imul_out;
  assign drained   = quiesce & (inflight == 4'd0);

endmodule

// File: tb/tb_riscv_imul_arb.sv
// Randomized and directed stimulus for riscv_imul_arb, scored against a
// transaction-level model of arbitration, result timing and occupancy.
module tb_riscv_imul_arb;
  import riscv_imul_arb_pkg::*;

  localparam int L    = 3;
  localparam int TAGW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 req0_val, req0_rdy, req1_val, req1_rdy;
  logic [VAU0_FN_W-1:0] req0_fn, req1_fn, cp_imul_fn;
  logic [XLEN-1:0]      req0_in0, req0_in1, req1_in0, req1_in1;
  logic [TAGW-1:0]      req0_tag, req1_tag, resp0_tag, resp1_tag;
  logic                 cp_imul_val, cp_imul_rdy;
  logic [XLEN-1:0]      cp_imul_in0, cp_imul_in1, cp_imul_out, resp_bits;
  logic                 resp0_val, resp1_val, quiesce, drained;
  logic [3:0]           inflight;

  riscv_imul_arb #(.LATENCY(L), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_fn(req0_fn),
    .req0_in0(req0_in0), .req0_in1(req0_in1), .req0_tag(req0_tag),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_fn(req1_fn),
    .req1_in0(req1_in0), .req1_in1(req1_in1), .req1_tag(req1_tag),
    .cp_imul_val(cp_imul_val), .cp_imul_rdy(cp_imul_rdy), .cp_imul_fn(cp_imul_fn),
    .cp_imul_in0(cp_imul_in0), .cp_imul_in1(cp_imul_in1), .cp_imul_out(cp_imul_out),
    .resp0_val(resp0_val), .resp0_tag(resp0_tag), .resp1_val(resp1_val),
    .resp1_tag(resp1_tag), .resp_bits(resp_bits),
    .quiesce(quiesce), .drained(drained), .inflight(inflight)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int              due;
    bit              id;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] prod;
  } ent_t;

  ent_t            exp_q[$];
  logic [XLEN-1:0] mul_at[int];
  int              cyc;
  int              last_win;
  int              n_checks;
  int              n_pass;

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // ---------------- driver ----------------
  bit              s_rst, s_v0, s_v1, s_q, s_rdy;
  logic [VAU0_FN_W-1:0] s_fn0, s_fn1;
  logic [XLEN-1:0] s_a0, s_b0, s_a1, s_b1;
  logic [TAGW-1:0] s_t0, s_t1;

  task automatic rand_ops();
    s_fn0 = VAU0_FN_W'($urandom); s_fn1 = VAU0_FN_W'($urandom);
    s_a0 = {$urandom, $urandom}; s_b0 = {$urandom, $urandom};
    s_a1 = {$urandom, $urandom}; s_b1 = {$urandom, $urandom};
    s_t0 = TAGW'($urandom); s_t1 = TAGW'($urandom);
  endtask

  task automatic set_ctl(input bit rst, input bit v0, input bit v1,
                         input bit q, input bit rdy);
    s_rst = rst; s_v0 = v0; s_v1 = v1; s_q = q; s_rdy = rdy;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    int   win;
    bit   any, exp_cpval, exp_fire, r0, r1;
    ent_t hit;
    bit   have_hit;
    int   occ;
    @(negedge clk);
    reset = s_rst; quiesce = s_q; cp_imul_rdy = s_rdy;
    req0_val = s_v0; req0_fn = s_fn0; req0_in0 = s_a0; req0_in1 = s_b0; req0_tag = s_t0;
    req1_val = s_v1; req1_fn = s_fn1; req1_in0 = s_a1; req1_in1 = s_b1; req1_tag = s_t1;
    cp_imul_out = mul_at.exists(cyc) ? mul_at[cyc] : '0;
    #1;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());

    any       = s_v0 | s_v1;
    win       = (s_v0 && s_v1) ? (1 - last_win) : (s_v1 ? 1 : 0);
    exp_cpval = any & ~s_q;
    exp_fire  = exp_cpval & s_rdy;
    check("cp_val", 64'(cp_imul_val), 64'(exp_cpval));
    check("rdy0", 64'(req0_rdy), 64'(exp_fire && win == 0));
    check("rdy1", 64'(req1_rdy), 64'(exp_fire && win == 1));
    check("cp_fn", 64'(cp_imul_fn), 64'(win == 1 ? s_fn1 : s_fn0));
    check("cp_in0", cp_imul_in0, win == 1 ? s_a1 : s_a0);
    check("cp_in1", cp_imul_in1, win == 1 ? s_b1 : s_b0);

    have_hit = 0;
    occ = exp_q.size();
    if (occ > 0 && exp_q[0].due == cyc) begin
      have_hit = 1;
      hit = exp_q[0];
    end
    r0 = have_hit && !s_rst && hit.id == 0;
    r1 = have_hit && !s_rst && hit.id == 1;
    check("resp0_val", 64'(resp0_val), 64'(r0));
    check("resp1_val", 64'(resp1_val), 64'(r1));
    if (r0) check("resp0_tag", 64'(resp0_tag), 64'(hit.tag));
    if (r1) check("resp1_tag", 64'(resp1_tag), 64'(hit.tag));
    if (r0 || r1) check("resp_bits", resp_bits, hit.prod);
    check("inflight", 64'(inflight), 64'(occ));
    check("drained", 64'(drained), 64'(s_q && occ == 0));

    // Multiplier stand-in: whatever is issued shows up L cycles later.
    if (cp_imul_val && cp_imul_rdy) mul_at[cyc + L] = cp_imul_in0 * cp_imul_in1;

    if (s_rst) begin
      exp_q.delete();
      last_win = 1;
    end else if (exp_fire) begin
      hit.due  = cyc + L;
      hit.id   = (win == 1);
      hit.tag  = (win == 1) ? s_t1 : s_t0;
      hit.prod = (win == 1) ? s_a1 * s_b1 : s_a0 * s_b0;
      exp_q.push_back(hit);
      last_win = win;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_ops();
      set_ctl(0, 0, 0, 0, 1);
      step();
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      rand_ops();
      set_ctl(1, 0, 0, 0, 1);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_win = 1;
    rand_ops();
    do_reset();

    // Single scalar multiply 3*4, tag 7.
    rand_ops();
    s_a0 = 64'd3; s_b0 = 64'd4; s_t0 = 5'd7;
    set_ctl(0, 1, 0, 0, 1);
    step();
    idle(5);

    // Contention, alternating grants after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_ops(); set_ctl(0, 1, 1, 0, 1); step();
    end
    idle(5);

    // Multiplier not ready, then ready.
    for (int i = 0; i < 3; i++) begin
      rand_ops(); set_ctl(0, 0, 1, 0, 0); step();
    end
    rand_ops(); set_ctl(0, 0, 1, 0, 1); step();
    idle(5);

    // Quiesce after two fires, pending results retire.
    for (int i = 0; i < 2; i++) begin
      rand_ops(); set_ctl(0, 1, 1, 0, 1); step();
    end
    for (int i = 0; i < 6; i++) begin
      rand_ops(); set_ctl(0, 1, 1, 1, 1); step();
    end
    idle(2);

    // Reset one cycle after a fire discards it; req0 wins next contention.
    rand_ops(); set_ctl(0, 0, 1, 0, 1); step();
    rand_ops(); set_ctl(1, 0, 0, 0, 1); step();
    rand_ops(); set_ctl(0, 1, 1, 0, 1); step();
    idle(5);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rand_ops();
      set_ctl($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0);
      step();
    end
    idle(L + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
